// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: ALU operation codes and the
// multiply/divide sequencer state encoding.
package riscv_pkg;

  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_MULH = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;
  localparam logic [3:0] ALU_REM  = 4'd13;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  function automatic logic is_muldiv(input logic [3:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REM);
  endfunction

  function automatic logic is_mul(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_MULH);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider core: one shift-subtract step per cycle on magnitudes.
// Next-step quotient/remainder are combinational so the caller can capture the final step.
module div_iter
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN-1:0]   dividend,
  input  logic [XLEN-1:0]   divisor,
  output logic [XLEN-1:0]   quo_next,
  output logic [XLEN-1:0]   rem_next,
  output logic              last
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dsr;
  logic [4:0]      cnt;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            fits;

  // Remainder is always below the divisor (<= 2^31), so the shifted value
  // fits in 33 bits and bit 32 of the trial difference is its sign.
  assign shifted  = {rem, quo[XLEN-1]};
  assign trial    = shifted - {1'b0, dsr};
  assign fits     = ~trial[XLEN];
  assign rem_next = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], fits};
  assign last     = (cnt == 5'(DIV_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
      cnt <= '0;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
      cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MULH/DIV/REM unit for the EX stage: MUL 2 cycles, DIV/REM 33, special divides 1.
// Holds the pipeline via stall until the result cycle; flush aborts silently.
module muldiv_sequencer
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         ALU_CON,
  input  logic signed [31:0] in_1,
  input  logic signed [31:0] in_2,
  input  logic               flush,
  output logic signed [31:0] out,
  output logic               done,
  output logic               busy,
  output logic               stall
);

  md_state_t       state;
  logic [3:0]      op;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic            neg_q;
  logic            neg_r;

  logic            valid_req;
  logic            accept;
  logic            req_div;
  logic            div_zero;
  logic            div_ovf;
  logic            div_load;
  logic            div_step;
  logic [31:0]     a_mag;
  logic [31:0]     b_mag;
  logic [63:0]     product;
  logic [31:0]     quo_next;
  logic [31:0]     rem_next;
  logic [31:0]     q_fix;
  logic [31:0]     r_fix;
  logic            div_last;

  assign valid_req = is_muldiv(ALU_CON);
  assign accept    = (state == ST_IDLE) && start && valid_req && !flush;
  assign req_div   = (ALU_CON == ALU_DIV) || (ALU_CON == ALU_REM);
  assign div_zero  = (in_2 == 32'sd0);
  assign div_ovf   = (in_1 == 32'sh8000_0000) && (in_2 == -32'sd1);
  assign div_load  = accept && req_div && !div_zero && !div_ovf;
  assign div_step  = (state == ST_DIV) && !flush;

  assign a_mag = in_1[31] ? (~in_1 + 32'd1) : in_1;
  assign b_mag = in_2[31] ? (~in_2 + 32'd1) : in_2;

  // Sign-extended 64x64 product; the low 64 bits equal the signed 32x32 product.
  assign product = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};

  assign q_fix = neg_q ? (~quo_next + 32'd1) : quo_next;
  assign r_fix = neg_r ? (~rem_next + 32'd1) : rem_next;

  // Held through MUL/DIV and on the accepting cycle; released in DONE.
  assign stall = !rst && ((state == ST_MUL) || (state == ST_DIV) ||
                          ((state == ST_IDLE) && start && valid_req));

  div_iter u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next),
    .last     (div_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              op    <= ALU_CON;
              op_a  <= in_1;
              op_b  <= in_2;
              neg_q <= in_1[31] ^ in_2[31];
              neg_r <= in_1[31];
              busy  <= 1'b1;
              if (is_mul(ALU_CON)) begin
                state <= ST_MUL;
              end else if (div_zero) begin
                state <= ST_DONE;
                done  <= 1'b1;
                out   <= (ALU_CON == ALU_DIV) ? 32'hFFFF_FFFF : in_1;
              end else if (div_ovf) begin
                state <= ST_DONE;
                done  <= 1'b1;
                out   <= (ALU_CON == ALU_DIV) ? 32'h8000_0000 : 32'h0000_0000;
              end else begin
                state <= ST_DIV;
              end
            end
          end
          ST_MUL: begin
            state <= ST_DONE;
            done  <= 1'b1;
            out   <= (op == ALU_MULH) ? product[63:32] : product[31:0];
          end
          ST_DIV: begin
            if (div_last) begin
              state <= ST_DONE;
              done  <= 1'b1;
              out   <= (op == ALU_DIV) ? q_fix : r_fix;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32, divide iteration count fixed at 32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: EX-stage request, sampled only in IDLE.
REQ-005 SHALL have port ALU_CON, input, 4 bits: operation code; 10=MUL, 11=MULH, 12=DIV, 13=REM.
REQ-006 SHALL have port in_1, input, 32 bits signed: multiplicand/dividend.
REQ-007 SHALL have port in_2, input, 32 bits signed: multiplier/divisor.
REQ-008 SHALL have port flush, input, 1 bit: abort the in-flight operation.
REQ-009 SHALL have port out, output, 32 bits signed: result register.
REQ-010 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port stall, output, 1 bit: pipeline hold request.

Function
REQ-013 SHALL implement four states: IDLE, MUL, DIV, DONE.
REQ-014 SHALL accept a request in IDLE when start=1 and ALU_CON is 10..13; it SHALL latch ALU_CON, in_1 and in_2 on that edge.
REQ-015 SHALL ignore start when ALU_CON is outside 10..13, or while busy=1.
REQ-016 SHALL go IDLE->MUL for codes 10/11; MUL SHALL form the full signed 64-bit product; MUL->DONE after exactly 1 cycle.
REQ-017 SHALL write product[31:0] to out for MUL and product[63:32] for MULH.
REQ-018 SHALL go IDLE->DIV for codes 12/13 with a nonzero divisor and not (dividend=-2^31 and divisor=-1).
REQ-019 DIV SHALL perform 32 restoring shift-subtract iterations on operand magnitudes, 1 per cycle; DIV->DONE after exactly 32 cycles.
REQ-020 SHALL give the quotient the sign of (dividend XOR divisor) and the remainder the sign of the dividend; quotient truncates toward zero.
REQ-021 SHALL, for divide by zero, go IDLE->DONE directly and produce quotient 0xFFFFFFFF and remainder = dividend.
REQ-022 SHALL, for -2^31 / -1, go IDLE->DONE directly and produce quotient 0x80000000 and remainder 0.
REQ-023 SHALL, in DONE, update out with the result, assert done for that single cycle, and return to IDLE on the next edge.
REQ-024 SHALL hold out unchanged between done pulses.
REQ-025 SHALL make latency from the accepting edge to done=1: MUL/MULH 2 cycles, DIV/REM 33 cycles, special divide cases 1 cycle.
REQ-026 SHALL drive stall combinationally as busy OR (state=IDLE AND start AND valid code), deasserted in the DONE cycle, so the EX instruction is held until its result is present.
REQ-027 SHALL, on flush=1 in any state, go to IDLE on the next edge with no done pulse and out unchanged.
REQ-028 SHALL give flush priority over start in the same cycle.
REQ-029 SHALL accept a new request in the cycle immediately after DONE, with no dead cycle beyond the IDLE cycle.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-divide, force state IDLE, out=0, done=0, busy=0, stall=0, and clear the iteration counter and operand registers.
REQ-031 SHALL remain in IDLE until the first start after rst deasserts.

Structure
REQ-032 SHALL take the ALU_CON operation codes (10..13) and the state encoding from the shared package riscv_pkg; the ALU uses the same codes.
REQ-033 SHALL place the divide iteration datapath (remainder/quotient shift register, 5-bit counter) in a sub-module div_iter; the control FSM, sign fix-up and multiplier stay in muldiv_sequencer.

Verification
REQ-034 SHALL verify: MUL 7 x -3 -> done at accept+2, out=0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> out=0x40000000.
REQ-035 SHALL verify: DIV -7/2 -> done at accept+33, out=0xFFFFFFFD; REM -7/2 -> out=0xFFFFFFFF; stall high the whole time.
REQ-036 SHALL verify: DIV 5/0 -> done at accept+1, out=0xFFFFFFFF; REM 5/0 -> out=5; DIV 0x80000000/-1 -> out=0x80000000.
REQ-037 SHALL verify: flush at DIV cycle 10 -> IDLE next edge, no done, out keeps its prior value; new MUL accepted next cycle.
REQ-038 SHALL verify: rst pulse at DIV cycle 20 -> out=0, busy=0 immediately; start with ALU_CON=2 -> ignored, stall=0.
